// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes.
// A miss on a dirty line writes the old block back before allocating the new one.
module data_cache (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busy_wait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

    state_t      state;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags [8];
    logic [31:0] data [8];
    logic        first;
    logic [2:0]  req_tag;
    logic [2:0]  req_idx;

    logic [2:0]  tag_in;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        hit;
    logic        request;
    logic        write_hit;
    logic        start_miss;
    logic        wb_done;
    logic        alloc_done;

    assign tag_in  = address[7:5];
    assign idx     = address[4:2];
    assign off     = address[1:0];
    assign request = read | write;
    assign hit     = valid[idx] && (tags[idx] == tag_in);

    assign write_hit  = (state == IDLE) && write && hit;
    assign start_miss = (state == IDLE) && request && !hit;
    // The first cycle in a transfer state never completes, so memory has a cycle to raise mem_busywait.
    assign wb_done    = (state == WRITE_BACK) && !first && !mem_busywait;
    assign alloc_done = (state == ALLOCATE) && !first && !mem_busywait;

    assign busy_wait = request && !((state == IDLE) && hit);
    assign readdata  = data[idx][{off, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            first     <= 1'b0;
            valid     <= 8'h00;
            dirty     <= 8'h00;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss) begin
                        first <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WRITE_BACK;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                        end
                    end else if (write_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                WRITE_BACK: begin
                    first <= 1'b0;
                    if (wb_done) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        first     <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    first <= 1'b0;
                    if (alloc_done) begin
                        state          <= IDLE;
                        mem_read       <= 1'b0;
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Arrays and transfer registers carry no reset; control bits above gate their use.
    always_ff @(posedge clk) begin
        if (start_miss) begin
            req_tag       <= tag_in;
            req_idx       <= idx;
            mem_writedata <= data[idx];
            if (valid[idx] && dirty[idx])
                mem_address <= {tags[idx], idx};
            else
                mem_address <= {tag_in, idx};
        end
        if (wb_done)
            mem_address <= {req_tag, req_idx};
        if (alloc_done) begin
            data[req_idx] <= mem_readdata;
            tags[req_idx] <= req_tag;
        end
        if (write_hit)
            data[idx][{off, 3'b000} +: 8] <= writedata;
    end

endmodule
